// File: rtl/spi_reg_pkg.sv
// rtl/spi_reg_pkg.sv - shared constants, state encoding and address helpers for spi_reg_slave
package spi_reg_pkg;

  localparam int CMD_BITS  = 8;
  localparam int DATA_BITS = 24;
  localparam int ADDR_W    = 7;

  localparam logic [ADDR_W-1:0] ADDR_LED     = 7'h00;
  localparam logic [ADDR_W-1:0] ADDR_PIN_OUT = 7'h01;
  localparam logic [ADDR_W-1:0] ADDR_PIN_OE  = 7'h02;
  localparam logic [ADDR_W-1:0] ADDR_PIN_IN  = 7'h03;
  localparam logic [ADDR_W-1:0] ADDR_ID      = 7'h04;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  // Only the three storage registers accept writes; everything else is dropped.
  function automatic logic is_writable(input logic [ADDR_W-1:0] addr);
    return (addr == ADDR_LED) || (addr == ADDR_PIN_OUT) || (addr == ADDR_PIN_OE);
  endfunction

endpackage

// File: rtl/spi_reg_slave_if.sv
// rtl/spi_reg_slave_if.sv - SPI configuration bus between the samd51 master and the register slave
interface spi_reg_slave_if;

  logic cfg_sck;
  logic cfg_si;
  logic cfg_cs;
  logic cfg_so;

  modport master (output cfg_sck, output cfg_si, output cfg_cs, input cfg_so);
  modport slave  (input cfg_sck, input cfg_si, input cfg_cs, output cfg_so);

endinterface

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - two-flop synchroniser with single-clk rise/fall pulses
module spi_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Two synchroniser stages followed by the history register used for edge detection.
  // The reset value matches the idle level of the line so no false edge follows reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
      prev_q <= RESET_VAL;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level = sync_q;
  assign rise  = sync_q & ~prev_q;
  assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/spi_reg_slave.sv
// rtl/spi_reg_slave.sv - oversampled SPI slave register file driving LED and user-pin vectors
module spi_reg_slave
  import spi_reg_pkg::*;
#(
  parameter int          PIN_W    = 24,
  parameter int          LED_W    = 16,
  parameter logic [23:0] ID_VALUE = 24'h0053F0
) (
  input  logic              clk,
  input  logic              rst,
  spi_reg_slave_if.slave    cfg,
  input  logic [PIN_W-1:0]  pin_in,
  output logic [LED_W-1:0]  led_bits,
  output logic [PIN_W-1:0]  pin_out,
  output logic [PIN_W-1:0]  pin_oe,
  output logic              wr_strobe
);

  logic sck_level, sck_rise, sck_fall;
  logic si_level, si_rise, si_fall;
  logic cs_level, cs_rise, cs_fall;

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sck (
    .clk(clk), .rst(rst), .din(cfg.cfg_sck),
    .level(sck_level), .rise(sck_rise), .fall(sck_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b0)) u_si (
    .clk(clk), .rst(rst), .din(cfg.cfg_si),
    .level(si_level), .rise(si_rise), .fall(si_fall)
  );

  // Chip select idles high, so its synchroniser resets high.
  spi_sync_edge #(.RESET_VAL(1'b1)) u_cs (
    .clk(clk), .rst(rst), .din(cfg.cfg_cs),
    .level(cs_level), .rise(cs_rise), .fall(cs_fall)
  );

  logic unused_sync;
  assign unused_sync = &{1'b0, sck_level, si_rise, si_fall, cs_level};

  state_t             state_q, state_d;
  logic [4:0]         bit_cnt_q;
  logic [22:0]        rx_sr_q;
  logic               rnw_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [23:0]        miso_sr_q;
  logic               so_q;
  logic               commit_q;
  logic [23:0]        wdata_q;
  logic [LED_W-1:0]   led_q;
  logic [PIN_W-1:0]   pin_out_q;
  logic [PIN_W-1:0]   pin_oe_q;
  logic               strobe_q;

  logic               frame_start;
  logic               shift_rx;
  logic               cmd_last;
  logic               data_last;
  logic               miso_shift;
  logic [ADDR_W-1:0]  addr_next;
  logic               rnw_next;
  logic [23:0]        wdata_next;
  logic [23:0]        rdata;

  // The bit arriving on this rise completes the command byte or the data word.
  assign addr_next  = {rx_sr_q[5:0], si_level};
  assign rnw_next   = rx_sr_q[6];
  assign wdata_next = {rx_sr_q, si_level};

  // Register readback, narrower registers zero-extended to the 24-bit data field.
  always_comb begin
    rdata = '0;
    case (addr_next)
      ADDR_LED:     rdata[LED_W-1:0] = led_q;
      ADDR_PIN_OUT: rdata[PIN_W-1:0] = pin_out_q;
      ADDR_PIN_OE:  rdata[PIN_W-1:0] = pin_oe_q;
      ADDR_PIN_IN:  rdata[PIN_W-1:0] = pin_in;
      ADDR_ID:      rdata            = ID_VALUE;
      default:      rdata            = '0;
    endcase
  end

  // Frame state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-clk control pulses; CS rise outranks every SCK event.
  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    shift_rx    = 1'b0;
    cmd_last    = 1'b0;
    data_last   = 1'b0;
    miso_shift  = 1'b0;
    if (cs_rise) begin
      state_d = IDLE;
    end else if (cs_fall) begin
      state_d     = CMD;
      frame_start = 1'b1;
    end else begin
      case (state_q)
        CMD: begin
          if (sck_rise) begin
            shift_rx = 1'b1;
            if (bit_cnt_q == 5'(CMD_BITS - 1)) begin
              cmd_last = 1'b1;
              state_d  = DATA;
            end
          end
        end
        DATA: begin
          if (sck_rise) begin
            shift_rx = 1'b1;
            if (bit_cnt_q == 5'(DATA_BITS - 1)) begin
              data_last = 1'b1;
              state_d   = DONE;
            end
          end else if (sck_fall) begin
            miso_shift = 1'b1;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Shift datapath: MOSI capture, command latch, MISO shifter and write commit request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q <= '0;
      rx_sr_q   <= '0;
      rnw_q     <= 1'b0;
      addr_q    <= '0;
      miso_sr_q <= '0;
      so_q      <= 1'b0;
      commit_q  <= 1'b0;
      wdata_q   <= '0;
    end else begin
      commit_q <= 1'b0;
      if (frame_start) begin
        bit_cnt_q <= '0;
        rx_sr_q   <= '0;
        miso_sr_q <= '0;
        so_q      <= 1'b0;
      end else if (cs_rise) begin
        so_q <= 1'b0;
      end else begin
        if (shift_rx) begin
          rx_sr_q   <= {rx_sr_q[21:0], si_level};
          bit_cnt_q <= cmd_last ? 5'd0 : bit_cnt_q + 5'd1;
        end
        if (cmd_last) begin
          rnw_q     <= rnw_next;
          addr_q    <= addr_next;
          miso_sr_q <= rnw_next ? rdata : 24'h0;
        end
        if (data_last) begin
          commit_q <= ~rnw_q & is_writable(addr_q);
          wdata_q  <= wdata_next;
        end
        if (sck_fall) begin
          so_q <= (state_q == DATA) ? miso_sr_q[23] : 1'b0;
          if (miso_shift) begin
            miso_sr_q <= {miso_sr_q[22:0], 1'b0};
          end
        end
      end
    end
  end

  // Storage registers update one clk after the commit request, with a matching strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q     <= '0;
      pin_out_q <= '0;
      pin_oe_q  <= '0;
      strobe_q  <= 1'b0;
    end else begin
      strobe_q <= commit_q;
      if (commit_q) begin
        case (addr_q)
          ADDR_LED:     led_q     <= wdata_q[LED_W-1:0];
          ADDR_PIN_OUT: pin_out_q <= wdata_q[PIN_W-1:0];
          ADDR_PIN_OE:  pin_oe_q  <= wdata_q[PIN_W-1:0];
          default:      led_q     <= led_q;
        endcase
      end
    end
  end

  assign cfg.cfg_so = so_q;
  assign led_bits   = led_q;
  assign pin_out    = pin_out_q;
  assign pin_oe     = pin_oe_q;
  assign wr_strobe  = strobe_q;

endmodule
